// File: rtl/go_turn_timer.sv
// go_turn_timer: per-player Go game clock with main time followed by Japanese byo-yomi
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   sec_level      1 Hz square wave from the clock generator (asynchronous, synchronised here)
//   start          pulse: reload all counters, black to move, enter RUN
//   move_done      pulse: player to move committed a stone or pass
//   pause          level: freeze timing while high
//   sec_phase_rst  pulse to the generator so each move starts on a fresh second
//   cur_player     0 = black, 1 = white
//   *_main         main seconds remaining
//   *_byo          seconds remaining in the current byo-yomi period
//   *_periods      byo-yomi periods remaining
//   *_in_byo       player has exhausted main time
//   running        state is RUN
//   timeout        game ended on time
//   loser          player who ran out of time (valid while timeout)
//   low_warn       player to move is in byo-yomi with few seconds left
module go_turn_timer #(
  parameter int MAIN_SECONDS = 600,
  parameter int BYO_SECONDS  = 30,
  parameter int BYO_PERIODS  = 3,
  parameter int CNT_W        = 10,
  parameter int BYO_W        = 6,
  parameter int PER_W        = 3,
  parameter int WARN_SECONDS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sec_level,
  input  logic             start,
  input  logic             move_done,
  input  logic             pause,
  output logic             sec_phase_rst,
  output logic             cur_player,
  output logic [CNT_W-1:0] black_main,
  output logic [CNT_W-1:0] white_main,
  output logic [BYO_W-1:0] black_byo,
  output logic [BYO_W-1:0] white_byo,
  output logic [PER_W-1:0] black_periods,
  output logic [PER_W-1:0] white_periods,
  output logic             black_in_byo,
  output logic             white_in_byo,
  output logic             running,
  output logic             timeout,
  output logic             loser,
  output logic             low_warn
);
  localparam logic [CNT_W-1:0] MAIN_L = CNT_W'(MAIN_SECONDS);
  localparam logic [CNT_W-1:0] MAIN_1 = CNT_W'(1);
  localparam logic [BYO_W-1:0] BYO_L  = BYO_W'(BYO_SECONDS);
  localparam logic [BYO_W-1:0] BYO_1  = BYO_W'(1);
  localparam logic [BYO_W-1:0] WARN_L = BYO_W'(WARN_SECONDS);
  localparam logic [PER_W-1:0] PER_L  = PER_W'(BYO_PERIODS);
  localparam logic [PER_W-1:0] PER_1  = PER_W'(1);
  localparam logic             INB_L  = (MAIN_SECONDS == 0);
  localparam logic             NO_BYO = (BYO_PERIODS == 0);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
  state_t state, state_nx;

  logic s1, s2, s3, tick;
  logic act_tick, act_move, upd, exhaust;
  logic [CNT_W-1:0] cur_main, nx_main;
  logic [BYO_W-1:0] cur_byo, nx_byo;
  logic [PER_W-1:0] cur_per, nx_per;
  logic             cur_inb, nx_inb;

  // two-flop synchroniser, edge register, and a registered tick so it lands
  // three cycles after the sec_level rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= sec_level;
      s2   <= s1;
      s3   <= s2;
      tick <= s2 & ~s3;
    end

  always_comb begin
    cur_main = cur_player ? white_main    : black_main;
    cur_byo  = cur_player ? white_byo     : black_byo;
    cur_per  = cur_player ? white_periods : black_periods;
    cur_inb  = cur_player ? white_in_byo  : black_in_byo;
  end

  // move_done beats a same-cycle tick; start beats everything
  assign act_move = move_done && state == RUN && !start;
  assign act_tick = tick && state == RUN && !move_done && !start;
  assign upd      = act_tick || act_move;
  assign exhaust  = act_tick && (cur_inb ? (cur_byo <= BYO_1 && cur_per <= PER_1)
                                         : (cur_main <= MAIN_1 && NO_BYO));

  // next values for the player to move; a move only refreshes the byo period
  always_comb begin
    nx_main = cur_main;
    nx_byo  = cur_byo;
    nx_per  = cur_per;
    nx_inb  = cur_inb;
    if (act_move)
      nx_byo = cur_inb ? BYO_L : cur_byo;
    else if (!cur_inb) begin
      nx_main = cur_main <= MAIN_1 ? '0 : cur_main - MAIN_1;
      nx_inb  = cur_main <= MAIN_1;
    end else if (cur_byo > BYO_1)
      nx_byo = cur_byo - BYO_1;
    else if (cur_per > PER_1) begin
      nx_per = cur_per - PER_1;
      nx_byo = BYO_L;
    end else begin
      nx_per = '0;
      nx_byo = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    if (start)
      state_nx = RUN;
    else if (state == RUN)
      state_nx = exhaust ? OVER : (pause ? PAUSE : RUN);
    else if (state == PAUSE)
      state_nx = pause ? PAUSE : RUN;
  end

  always_comb begin
    running  = state == RUN;
    low_warn = running && cur_inb && cur_byo <= WARN_L;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sec_phase_rst <= 1'b0;
      cur_player    <= 1'b0;
      timeout       <= 1'b0;
      loser         <= 1'b0;
      black_main    <= MAIN_L;
      white_main    <= MAIN_L;
      black_byo     <= BYO_L;
      white_byo     <= BYO_L;
      black_periods <= PER_L;
      white_periods <= PER_L;
      black_in_byo  <= INB_L;
      white_in_byo  <= INB_L;
    end else if (start) begin
      sec_phase_rst <= 1'b1;
      cur_player    <= 1'b0;
      timeout       <= 1'b0;
      loser         <= 1'b0;
      black_main    <= MAIN_L;
      white_main    <= MAIN_L;
      black_byo     <= BYO_L;
      white_byo     <= BYO_L;
      black_periods <= PER_L;
      white_periods <= PER_L;
      black_in_byo  <= INB_L;
      white_in_byo  <= INB_L;
    end else begin
      sec_phase_rst <= act_move;
      if (act_move) cur_player <= ~cur_player;
      if (exhaust) begin
        timeout <= 1'b1;
        loser   <= cur_player;
      end
      if (upd && !cur_player) begin
        black_main    <= nx_main;
        black_byo     <= nx_byo;
        black_periods <= nx_per;
        black_in_byo  <= nx_inb;
      end
      if (upd && cur_player) begin
        white_main    <= nx_main;
        white_byo     <= nx_byo;
        white_periods <= nx_per;
        white_in_byo  <= nx_inb;
      end
    end
endmodule

// File: tb/tb_go_turn_timer.sv
// tb_go_turn_timer: directed vector bench for go_turn_timer (default and short-byo instances)
module tb_go_turn_timer;
  localparam int OP_START = 0, OP_TICK = 1, OP_MOVE = 2, OP_COLL = 3, OP_PON = 4, OP_POFF = 5;

  typedef struct {
    int op;
    int pl;
    int bm;
    int wm;
    int run;
    int ph;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, sec_level = 1'b0, start = 1'b0, move_done = 1'b0, pause = 1'b0;

  logic       a_ph, a_pl, a_binb, a_winb, a_run, a_to, a_los, a_warn;
  logic [9:0] a_bm, a_wm;
  logic [5:0] a_bb, a_wb;
  logic [2:0] a_bp, a_wp;
  logic       b_ph, b_pl, b_binb, b_winb, b_run, b_to, b_los, b_warn;
  logic [9:0] b_bm, b_wm;
  logic [5:0] b_bb, b_wb;
  logic [2:0] b_bp, b_wp;

  int total = 0, bad = 0, ph_a = 0;
  vec_t tbl[20];

  always #5 clk = ~clk;

  go_turn_timer u_a (
    .clk(clk), .rst_n(rst_n), .sec_level(sec_level), .start(start), .move_done(move_done), .pause(pause),
    .sec_phase_rst(a_ph), .cur_player(a_pl), .black_main(a_bm), .white_main(a_wm),
    .black_byo(a_bb), .white_byo(a_wb), .black_periods(a_bp), .white_periods(a_wp),
    .black_in_byo(a_binb), .white_in_byo(a_winb), .running(a_run), .timeout(a_to),
    .loser(a_los), .low_warn(a_warn)
  );

  go_turn_timer #(.MAIN_SECONDS(2), .BYO_SECONDS(3), .BYO_PERIODS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sec_level(sec_level), .start(start), .move_done(move_done), .pause(pause),
    .sec_phase_rst(b_ph), .cur_player(b_pl), .black_main(b_bm), .white_main(b_wm),
    .black_byo(b_bb), .white_byo(b_wb), .black_periods(b_bp), .white_periods(b_wp),
    .black_in_byo(b_binb), .white_in_byo(b_winb), .running(b_run), .timeout(b_to),
    .loser(b_los), .low_warn(b_warn)
  );

  always @(posedge clk) if (a_ph) ph_a <= ph_a + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_op(input int op);
    case (op)
      OP_START, OP_MOVE: begin
        @(negedge clk);
        if (op == OP_START) start = 1'b1; else move_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        move_done = 1'b0;
        @(negedge clk);
      end
      OP_TICK: begin
        @(negedge clk) sec_level = 1'b1;
        repeat (4) @(negedge clk);
        sec_level = 1'b0;
        repeat (3) @(negedge clk);
      end
      OP_COLL: begin
        @(negedge clk) sec_level = 1'b1;
        repeat (3) @(negedge clk);
        move_done = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        sec_level = 1'b0;
        repeat (3) @(negedge clk);
      end
      OP_PON:  begin @(negedge clk) pause = 1'b1; repeat (2) @(negedge clk); end
      default: begin @(negedge clk) pause = 1'b0; repeat (2) @(negedge clk); end
    endcase
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_bm"}, a_bm, 600);
    chk({tag, "_a_wm"}, a_wm, 600);
    chk({tag, "_a_bb"}, a_bb, 30);
    chk({tag, "_a_wp"}, a_wp, 3);
    chk({tag, "_a_binb"}, a_binb, 0);
    chk({tag, "_a_pl"}, a_pl, 0);
    chk({tag, "_a_run"}, a_run, 0);
    chk({tag, "_a_ph"}, a_ph, 0);
    chk({tag, "_a_to"}, a_to, 0);
    chk({tag, "_b_bm"}, b_bm, 2);
    chk({tag, "_b_bb"}, b_bb, 3);
    chk({tag, "_b_bp"}, b_bp, 2);
    chk({tag, "_b_binb"}, b_binb, 0);
    chk({tag, "_b_pl"}, b_pl, 0);
    chk({tag, "_b_to"}, b_to, 0);
    chk({tag, "_b_los"}, b_los, 0);
    chk({tag, "_b_warn"}, b_warn, 0);
  endtask

  initial begin
    tbl[0]  = '{OP_START, 0, 600, 600, 1, 1};
    tbl[1]  = '{OP_TICK,  0, 599, 600, 1, 0};
    tbl[2]  = '{OP_TICK,  0, 598, 600, 1, 0};
    tbl[3]  = '{OP_TICK,  0, 597, 600, 1, 0};
    tbl[4]  = '{OP_START, 0, 600, 600, 1, 1};
    tbl[5]  = '{OP_TICK,  0, 599, 600, 1, 0};
    tbl[6]  = '{OP_TICK,  0, 598, 600, 1, 0};
    tbl[7]  = '{OP_MOVE,  1, 598, 600, 1, 1};
    tbl[8]  = '{OP_TICK,  1, 598, 599, 1, 0};
    tbl[9]  = '{OP_COLL,  0, 598, 599, 1, 1};
    tbl[10] = '{OP_TICK,  0, 597, 599, 1, 0};
    tbl[11] = '{OP_PON,   0, 597, 599, 0, 0};
    tbl[12] = '{OP_TICK,  0, 597, 599, 0, 0};
    tbl[13] = '{OP_TICK,  0, 597, 599, 0, 0};
    tbl[14] = '{OP_TICK,  0, 597, 599, 0, 0};
    tbl[15] = '{OP_TICK,  0, 597, 599, 0, 0};
    tbl[16] = '{OP_TICK,  0, 597, 599, 0, 0};
    tbl[17] = '{OP_MOVE,  0, 597, 599, 0, 0};
    tbl[18] = '{OP_POFF,  0, 597, 599, 1, 0};
    tbl[19] = '{OP_TICK,  0, 596, 599, 1, 0};

    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // tick latency: counter moves on the fourth edge after the sec_level rise
    do_op(OP_START);
    @(negedge clk) sec_level = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_before", a_bm, 600);
    @(negedge clk);
    chk("lat_after", a_bm, 599);
    sec_level = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      int p0;
      p0 = ph_a;
      do_op(tbl[i].op);
      chk($sformatf("v%0d_pl", i), a_pl, tbl[i].pl);
      chk($sformatf("v%0d_bm", i), a_bm, tbl[i].bm);
      chk($sformatf("v%0d_wm", i), a_wm, tbl[i].wm);
      chk($sformatf("v%0d_run", i), a_run, tbl[i].run);
      chk($sformatf("v%0d_ph", i), ph_a - p0, tbl[i].ph);
    end

    // byo-yomi entry, period roll, reload on move, timeout
    do_op(OP_START);
    chk("b_start_bm", b_bm, 2);
    chk("b_start_warn", b_warn, 0);
    do_op(OP_TICK);
    chk("b_t1_bm", b_bm, 1);
    do_op(OP_TICK);
    chk("b_t2_bm", b_bm, 0);
    chk("b_t2_inb", b_binb, 1);
    chk("b_t2_bb", b_bb, 3);
    chk("b_t2_warn", b_warn, 1);
    do_op(OP_TICK);
    chk("b_t3_bb", b_bb, 2);
    do_op(OP_TICK);
    chk("b_t4_bb", b_bb, 1);
    do_op(OP_TICK);
    chk("b_t5_bp", b_bp, 1);
    chk("b_t5_bb", b_bb, 3);
    chk("b_t5_warn", b_warn, 1);
    do_op(OP_TICK);
    do_op(OP_TICK);
    chk("b_t7_bb", b_bb, 1);
    do_op(OP_MOVE);
    chk("b_mv_bb", b_bb, 3);
    chk("b_mv_bp", b_bp, 1);
    chk("b_mv_pl", b_pl, 1);
    chk("b_mv_warn", b_warn, 0);
    do_op(OP_MOVE);
    chk("b_mv2_pl", b_pl, 0);
    chk("b_mv2_wm", b_wm, 2);
    do_op(OP_TICK);
    do_op(OP_TICK);
    chk("b_pre_to", b_to, 0);
    do_op(OP_TICK);
    chk("b_to", b_to, 1);
    chk("b_los", b_los, 0);
    chk("b_to_bp", b_bp, 0);
    chk("b_to_bb", b_bb, 0);
    chk("b_to_run", b_run, 0);
    chk("b_to_warn", b_warn, 0);
    do_op(OP_TICK);
    do_op(OP_MOVE);
    chk("b_over_pl", b_pl, 0);
    chk("b_over_bb", b_bb, 0);
    chk("b_over_wm", b_wm, 2);
    chk("b_over_to", b_to, 1);
    do_op(OP_START);
    chk("b_rs_to", b_to, 0);
    chk("b_rs_bm", b_bm, 2);
    chk("b_rs_bb", b_bb, 3);
    chk("b_rs_bp", b_bp, 2);
    chk("b_rs_inb", b_binb, 0);
    chk("b_rs_run", b_run, 1);

    // asynchronous reset in the middle of a run
    do_op(OP_TICK);
    do_op(OP_MOVE);
    chk("pre_rst_pl", a_pl, 1);
    chk("pre_rst_bm", b_bm, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/go_turn_timer.md
Name: go_turn_timer

Overview:
- Per-player game clock for the Go board: main time, then Japanese byo-yomi (fixed seconds per period, N periods).
- Sits directly downstream of the clock generator. Samples its 1 Hz output as a data level on the system clock and counts seconds.
- Drives the generator's 1 Hz phase-restart input so each move begins a fresh second.
- Outputs feed the score/time display and the buzzer logic.

Parameters:
- MAIN_SECONDS, 600, main time per player in seconds (0 = start directly in byo-yomi).
- BYO_SECONDS, 30, seconds per byo-yomi period (must be ≥1).
- BYO_PERIODS, 3, number of byo-yomi periods (0 = no byo-yomi, timeout at end of main time).
- CNT_W, 10, width of the main-time counters (must hold MAIN_SECONDS).
- BYO_W, 6, width of the byo-yomi second counters.
- PER_W, 3, width of the period counters.
- WARN_SECONDS, 5, low-time warning threshold in byo-yomi.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- sec_level  in  1  1 Hz square wave from the clock generator, asynchronous to the timer's logic, sampled here.
- start  in  1  one-cycle pulse: load all counters and begin with black to move.
- move_done  in  1  one-cycle pulse: the player to move has committed a stone or a pass.
- pause  in  1  level: freeze timing while high.
- sec_phase_rst  out  1  one-cycle pulse to the clock generator's 1 Hz reset input.
- cur_player  out  1  0 = black, 1 = white.
- black_main, white_main  out  CNT_W  main seconds remaining.
- black_byo, white_byo  out  BYO_W  seconds remaining in the current period.
- black_periods, white_periods  out  PER_W  periods remaining.
- black_in_byo, white_in_byo  out  1  player has exhausted main time.
- running  out  1  state is RUN.
- timeout  out  1  game ended on time.
- loser  out  1  player who ran out of time (valid while timeout = 1).
- low_warn  out  1  player to move is in byo-yomi with byo ≤ WARN_SECONDS.

Behaviour:
- Reset (async):
  - state IDLE; cur_player 0.
  - *_main = MAIN_SECONDS; *_byo = BYO_SECONDS; *_periods = BYO_PERIODS.
  - *_in_byo = (MAIN_SECONDS == 0).
  - sec_phase_rst, running, timeout, loser, low_warn = 0.
  - Synchronizer and edge registers = 0.
- Tick generation:
  - sec_level passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is high for one cycle, 3 clk cycles after the sec_level rise.
- States:
  - IDLE –start→ RUN.
  - RUN –pause=1→ PAUSE.
  - PAUSE –pause=0→ RUN.
  - RUN –exhaustion→ OVER.
  - OVER holds until start.
- start (highest priority, any state):
  - Reload all counters as at reset.
  - cur_player = 0; clear timeout and loser; state RUN.
  - Pulse sec_phase_rst the following cycle.
- tick in RUN, applied to the player to move only:
  - in_byo = 0 and main > 1: main − 1.
  - in_byo = 0 and main == 1: main = 0 and in_byo = 1. If BYO_PERIODS == 0: go to OVER, timeout = 1, loser = cur_player.
  - in_byo = 1 and byo > 1: byo − 1.
  - in_byo = 1 and byo == 1 and periods > 1: periods − 1, byo = BYO_SECONDS.
  - in_byo = 1 and byo == 1 and periods == 1: periods = 0, byo = 0, go to OVER, timeout = 1, loser = cur_player.
- move_done in RUN:
  - If the mover is in byo-yomi, reload their byo to BYO_SECONDS; the period is not consumed.
  - Toggle cur_player.
  - sec_phase_rst = 1 the next cycle, for exactly one cycle.
- Ignored events:
  - move_done in IDLE, PAUSE or OVER.
  - tick outside RUN.
- Simultaneous events:
  - tick and move_done in the same cycle: move_done wins and the tick is discarded; the mover's counters are not decremented.
  - start with anything: start wins.
- The opponent's counters never change on a tick.
- low_warn is combinational from the current player's registers: in_byo && byo ≤ WARN_SECONDS && state == RUN.
- Counters never wrap below 0.

Test Plan:
- Main time countdown: reset; start; apply 3 sec_level rising edges → black_main = 597, white_main = 600, tick observed 3 clk after each edge, sec_phase_rst pulsed once after start.
- Move and phase restart: start; 2 ticks; move_done → cur_player = 1, black_main = 598, one sec_phase_rst pulse; next tick → white_main = 599.
- Entry into byo-yomi (MAIN_SECONDS=2, BYO_SECONDS=3, BYO_PERIODS=2): start; 2 ticks → black_in_byo = 1; 3 ticks → black_periods = 1, black_byo = 3; low_warn = 1 throughout with WARN_SECONDS=5.
- Timeout: continue the byo-yomi case with 3 more ticks → state OVER, timeout = 1, loser = 0, black_periods = 0; further ticks and move_done → no change; start → all counters reloaded, timeout = 0.
- Collision and pause: tick and move_done in the same cycle → mover's count unchanged, player toggles; pause = 1 across 5 ticks → no decrement, move_done ignored; release → counting resumes.
- Byo-yomi reload and async reset: move_done while in byo with byo = 1 → mover's byo = BYO_SECONDS, periods unchanged; assert rst_n low mid-RUN → all outputs at reset values immediately.
